// File: rtl/qed_inst_constraint_seq_if.sv
// Fetch-side bundle between the symbolic instruction source and the QED constraint checker.
// The master side drives the instruction stream; the slave side returns the legality verdict and run status.
interface qed_inst_constraint_seq_if #(
  parameter int CNT_W = 8
);
  logic             enable;
  logic             inst_valid;
  logic [31:0]      instruction;
  logic             inst_legal;
  logic [4:0]       inst_class;
  logic [1:0]       state;
  logic [CNT_W-1:0] inst_count;
  logic [CNT_W-1:0] mem_count;
  logic             violation;
  logic [2:0]       violation_code;

  modport master (
    output enable, inst_valid, instruction,
    input  inst_legal, inst_class, state, inst_count, mem_count, violation, violation_code
  );

  modport slave (
    input  enable, inst_valid, instruction,
    output inst_legal, inst_class, state, inst_count, mem_count, violation, violation_code
  );
endinterface

// File: rtl/qed_inst_constraint_seq.sv
// Checks each fetched RV32 word against the QED-legal subset and a per-run program budget.
// Legality and class are combinational; counters, state and the sticky first violation update on the next edge.
module qed_inst_constraint_seq #(
  parameter int         ORIG_REGS = 16,
  parameter logic [4:0] CLASS_EN  = 5'h1F,
  parameter bit         MUL_EN    = 1'b0,
  parameter int         MAX_INSTS = 16,
  parameter int         MAX_MEM   = 4,
  parameter int         DRAIN_CYC = 8,
  parameter int         CNT_W     = 8,
  parameter bit         ASSUME_EN = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  qed_inst_constraint_seq_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_ACTIVE = 2'b01;
  localparam logic [1:0] S_DRAIN  = 2'b10;
  localparam logic [1:0] S_DONE   = 2'b11;

  localparam int               DW          = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [5:0]       REG_LIM     = 6'(ORIG_REGS);
  localparam logic [CNT_W-1:0] MAX_INSTS_C = CNT_W'(MAX_INSTS);
  localparam logic [CNT_W-1:0] MAX_MEM_C   = CNT_W'(MAX_MEM);
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;
  localparam logic [DW-1:0]    DRAIN_LAST  = DW'(DRAIN_CYC - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_inst_count;
  logic [CNT_W-1:0] r_mem_count;
  logic [DW-1:0]    r_drain_cnt;
  logic             r_violation;
  logic [2:0]       r_violation_code;

  logic [6:0] w_opc;
  logic [6:0] w_f7;
  logic [2:0] w_f3;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;

  assign w_opc = bus.instruction[6:0];
  assign w_rd  = bus.instruction[11:7];
  assign w_f3  = bus.instruction[14:12];
  assign w_rs1 = bus.instruction[19:15];
  assign w_rs2 = bus.instruction[24:20];
  assign w_f7  = bus.instruction[31:25];

  logic w_f7_zero, w_f7_alt, w_f7_mul;
  logic w_i_f7_ok, w_mem_shape;
  logic w_is_i, w_is_lw, w_is_r, w_is_sw, w_is_nop;
  logic [4:0] w_class;

  assign w_f7_zero = (w_f7 == 7'b0000000);
  assign w_f7_alt  = (w_f7 == 7'b0100000);
  assign w_f7_mul  = (w_f7 == 7'b0000001);

  // Only the shift-immediates reuse instr[31:25] as funct7; every other I-op carries a free immediate there
  assign w_i_f7_ok = (w_f3 == 3'b001) ? w_f7_zero :
                     (w_f3 == 3'b101) ? (w_f7_zero | w_f7_alt) : 1'b1;

  // Word access, base x0, offset restricted to the low 1 KiB
  assign w_mem_shape = (w_f3 == 3'b010) && (w_rs1 == 5'd0) && (bus.instruction[31:30] == 2'b00);

  assign w_is_i   = (w_opc == 7'b0010011) && w_i_f7_ok;
  assign w_is_lw  = (w_opc == 7'b0000011) && w_mem_shape;
  assign w_is_sw  = (w_opc == 7'b0100011) && w_mem_shape;
  assign w_is_r   = (w_opc == 7'b0110011) &&
                    (w_f7_zero ||
                     (w_f7_alt && ((w_f3 == 3'b000) || (w_f3 == 3'b101))) ||
                     (MUL_EN && w_f7_mul && !w_f3[2]));
  assign w_is_nop = (w_opc == 7'b1111111);
  assign w_class  = {w_is_nop, w_is_sw, w_is_r, w_is_lw, w_is_i};

  logic w_rd_ok, w_rs1_ok, w_rs2_ok, w_reg_bad, w_is_mem;
  assign w_rd_ok  = ({1'b0, w_rd}  < REG_LIM);
  assign w_rs1_ok = ({1'b0, w_rs1} < REG_LIM);
  assign w_rs2_ok = ({1'b0, w_rs2} < REG_LIM);

  assign w_reg_bad = (w_is_i  && !(w_rd_ok && w_rs1_ok)) ||
                     (w_is_lw && !w_rd_ok) ||
                     (w_is_sw && !w_rs2_ok) ||
                     (w_is_r  && !(w_rd_ok && w_rs1_ok && w_rs2_ok));
  assign w_is_mem  = w_is_lw | w_is_sw;

  logic [2:0] w_cause;
  always_comb begin
    w_cause = 3'd0;
    if (!(|(w_class & CLASS_EN)))
      w_cause = 3'd1;
    else if (w_reg_bad)
      w_cause = 3'd2;
    else if (w_is_mem && (r_mem_count == MAX_MEM_C))
      w_cause = 3'd3;
    else if (!w_is_nop && r_state[1])
      w_cause = 3'd4;
  end

  logic w_legal, w_accept;
  logic [CNT_W-1:0] w_inst_inc, w_mem_inc;

  assign w_legal  = !bus.enable || !bus.inst_valid || (w_cause == 3'd0);
  // IDLE is treated like ACTIVE so the instruction that starts the run is counted
  assign w_accept = bus.enable && bus.inst_valid && (w_cause == 3'd0) && !w_is_nop && !r_state[1];

  assign w_inst_inc = (r_inst_count == CNT_SAT) ? r_inst_count : r_inst_count + 1'b1;
  assign w_mem_inc  = (r_mem_count  == CNT_SAT) ? r_mem_count  : r_mem_count  + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= S_IDLE;
      r_inst_count     <= '0;
      r_mem_count      <= '0;
      r_drain_cnt      <= '0;
      r_violation      <= 1'b0;
      r_violation_code <= 3'd0;
    end else if (bus.enable) begin
      if (bus.inst_valid && (w_cause != 3'd0) && !r_violation) begin
        r_violation      <= 1'b1;
        r_violation_code <= w_cause;
      end

      if (w_accept) begin
        r_inst_count <= w_inst_inc;
        if (w_is_mem)
          r_mem_count <= w_mem_inc;
      end

      case (r_state)
        S_IDLE, S_ACTIVE: begin
          if (w_accept && (w_inst_inc == MAX_INSTS_C))
            r_state <= S_DRAIN;
          else if (bus.inst_valid)
            r_state <= S_ACTIVE;
        end
        S_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST)
            r_state <= S_DONE;
          else
            r_drain_cnt <= r_drain_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.inst_legal     = w_legal;
  assign bus.inst_class     = w_class;
  assign bus.state          = r_state;
  assign bus.inst_count     = r_inst_count;
  assign bus.mem_count      = r_mem_count;
  assign bus.violation      = r_violation;
  assign bus.violation_code = r_violation_code;

  generate
    if (ASSUME_EN) begin : g_assume
`ifdef FORMAL
      always @(posedge i_clk) begin
        assume (!bus.inst_valid || bus.inst_legal);
      end
`endif
    end
  endgenerate

endmodule

// File: tb/tb_qed_inst_constraint_seq.sv
// Directed scenarios plus randomized instruction streams, each cycle compared against a
// rule-level reference model of decode legality and the per-run budget.
module tb_qed_inst_constraint_seq;

  localparam int ORIG_REGS = 16;
  localparam int MAX_INSTS = 16;
  localparam int MAX_MEM   = 4;
  localparam int DRAIN_CYC = 8;
  localparam int CNT_W     = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  qed_inst_constraint_seq_if #(.CNT_W(CNT_W)) bus ();

  qed_inst_constraint_seq #(
    .ORIG_REGS (ORIG_REGS),
    .CLASS_EN  (5'h1F),
    .MUL_EN    (1'b0),
    .MAX_INSTS (MAX_INSTS),
    .MAX_MEM   (MAX_MEM),
    .DRAIN_CYC (DRAIN_CYC),
    .CNT_W     (CNT_W),
    .ASSUME_EN (1'b1)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: run progress expressed as counts, not as an FSM
  int m_cnt, m_mem, m_drain, m_code;
  bit m_started, m_viol;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int exp_state();
    if (!m_started)            return 0;
    if (m_cnt < MAX_INSTS)     return 1;
    if (m_drain < DRAIN_CYC)   return 2;
    return 3;
  endfunction

  function automatic bit reg_bad(input logic [4:0] r);
    return int'(r) >= ORIG_REGS;
  endfunction

  function automatic void ref_decode(input logic [31:0] ins, output logic [4:0] cls, output bit rb);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    bit ok;
    int kind;
    opc = ins[6:0];  rd = ins[11:7];  f3 = ins[14:12];
    rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
    ok = 1'b0; rb = 1'b0; kind = 0;
    case (opc)
      7'h13: begin
        kind = 0;
        if (f3 == 3'd1)      ok = (f7 == 7'h00);
        else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
        else                 ok = 1'b1;
        rb = reg_bad(rd) || reg_bad(rs1);
      end
      7'h03: begin
        kind = 1;
        ok = (f3 == 3'd2) && (rs1 == 5'd0) && (ins[31:30] == 2'b00);
        rb = reg_bad(rd);
      end
      7'h33: begin
        kind = 2;
        ok = (f7 == 7'h00) || ((f7 == 7'h20) && (f3 inside {3'd0, 3'd5}));
        rb = reg_bad(rd) || reg_bad(rs1) || reg_bad(rs2);
      end
      7'h23: begin
        kind = 3;
        ok = (f3 == 3'd2) && (rs1 == 5'd0) && (ins[31:30] == 2'b00);
        rb = reg_bad(rs2);
      end
      7'h7F: begin
        kind = 4;
        ok = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    cls = ok ? (5'b00001 << kind) : 5'b00000;
    if (!ok) rb = 1'b0;
  endfunction

  task automatic check_regs(input string tag);
    check_val({tag, ".state"}, 32'(bus.state), 32'(exp_state()));
    check_val({tag, ".icnt"},  32'(bus.inst_count), 32'(m_cnt));
    check_val({tag, ".mcnt"},  32'(bus.mem_count), 32'(m_mem));
    check_val({tag, ".viol"},  32'(bus.violation), 32'(m_viol));
    check_val({tag, ".code"},  32'(bus.violation_code), 32'(m_code));
  endtask

  task automatic model_reset();
    m_cnt = 0; m_mem = 0; m_drain = 0; m_code = 0;
    m_started = 1'b0; m_viol = 1'b0;
  endtask

  // Asserted mid-cycle so the checks below prove the reset acts without a clock edge
  task automatic apply_reset(input string tag);
    @(negedge clk);
    bus.enable = 1'b1; bus.inst_valid = 1'b0; bus.instruction = 32'h0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_regs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input bit en, input bit vld, input logic [31:0] ins, input string tag);
    logic [4:0] cls;
    bit rb, legal;
    int code, st;
    @(negedge clk);
    bus.enable = en; bus.inst_valid = vld; bus.instruction = ins;
    #1;
    ref_decode(ins, cls, rb);
    st = exp_state();
    if (cls == 5'd0)                                 code = 1;
    else if (rb)                                     code = 2;
    else if ((cls[1] || cls[3]) && m_mem == MAX_MEM) code = 3;
    else if (!cls[4] && st >= 2)                     code = 4;
    else                                             code = 0;
    legal = !en || !vld || (code == 0);
    check_val({tag, ".legal"}, 32'(bus.inst_legal), 32'(legal));
    check_val({tag, ".class"}, 32'(bus.inst_class), 32'(cls));
    @(posedge clk);
    if (en) begin
      if (vld && code != 0 && !m_viol) begin
        m_viol = 1'b1;
        m_code = code;
      end
      if (st == 2) m_drain++;
      if (vld && code == 0 && !cls[4] && st <= 1) begin
        m_cnt++;
        if (cls[1] || cls[3]) m_mem++;
      end
      if (vld) m_started = 1'b1;
    end
    #1;
    check_regs(tag);
  endtask

  function automatic logic [4:0] rand_reg();
    if ($urandom_range(0, 7) == 0) return 5'($urandom_range(16, 31));
    return 5'($urandom_range(0, 15));
  endfunction

  function automatic logic [6:0] rand_f7();
    case ($urandom_range(0, 3))
      0:       return 7'h00;
      1:       return 7'h20;
      2:       return 7'h01;
      default: return 7'($urandom_range(0, 127));
    endcase
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    int k;
    k   = $urandom_range(0, 11);
    rd  = rand_reg(); rs1 = rand_reg(); rs2 = rand_reg();
    f3  = 3'($urandom_range(0, 7));
    f7  = 7'h00;
    opc = 7'h13;
    if (k <= 5) begin
      opc = 7'h13;
      if ($urandom_range(0, 3) == 0) f7 = rand_f7();
    end else if (k == 6 || k == 7) begin
      opc = (k == 6) ? 7'h03 : 7'h23;
      if ($urandom_range(0, 5) != 0) f3 = 3'd2;
      if ($urandom_range(0, 5) != 0) rs1 = 5'd0;
      f7 = {($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 5'($urandom_range(0, 31))};
    end else if (k == 8) begin
      opc = 7'h33;
      f7  = rand_f7();
    end else if (k == 9) begin
      opc = 7'h7F;
      f7  = 7'($urandom_range(0, 127));
    end else begin
      return $urandom();
    end
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  localparam logic [31:0] ADDI_X1 = 32'h00510093;
  localparam logic [31:0] LW_X1   = 32'h00002083;
  localparam logic [31:0] SW_X1   = 32'h00102023;
  localparam logic [31:0] NOP_W   = 32'h0000007F;

  initial begin
    bus.enable = 1'b0; bus.inst_valid = 1'b0; bus.instruction = 32'h0;
    model_reset();

    // T1: first ADDI starts the run and counts
    apply_reset("t1_rst");
    step(1'b1, 1'b1, ADDI_X1, "t1");
    check_val("t1_state_const", 32'(bus.state), 32'd1);
    check_val("t1_icnt_const",  32'(bus.inst_count), 32'd1);

    // T2: register x17 outside the 16-register window
    step(1'b1, 1'b1, {7'h00, 5'd2, 5'd1, 3'd0, 5'd17, 7'h33}, "t2");
    check_val("t2_code_const", 32'(bus.violation_code), 32'd2);
    check_val("t2_icnt_const", 32'(bus.inst_count), 32'd1);

    // T3: memory budget exhausted on the fifth load
    apply_reset("t3_rst");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, LW_X1, "t3");
    check_val("t3_mcnt_const", 32'(bus.mem_count), 32'd4);
    check_val("t3_code_const", 32'(bus.violation_code), 32'd3);

    // T4: instruction budget, then drain window
    apply_reset("t4_rst");
    for (int i = 0; i < MAX_INSTS; i++) step(1'b1, 1'b1, ADDI_X1, "t4a");
    check_val("t4_drain_const", 32'(bus.state), 32'd2);
    step(1'b1, 1'b1, ADDI_X1, "t4b");
    check_val("t4_code_const", 32'(bus.violation_code), 32'd4);
    for (int i = 0; i < DRAIN_CYC - 1; i++) step(1'b1, 1'b1, NOP_W, "t4c");
    check_val("t4_done_const", 32'(bus.state), 32'd3);
    step(1'b1, 1'b1, NOP_W, "t4d");

    // T5: the first cause sticks
    apply_reset("t5_rst");
    for (int i = 0; i < MAX_MEM; i++) step(1'b1, 1'b1, LW_X1, "t5a");
    step(1'b1, 1'b1, SW_X1, "t5b");
    step(1'b1, 1'b1, {7'h00, 5'd20, 5'd1, 3'd0, 5'd1, 7'h33}, "t5c");
    check_val("t5_code_const", 32'(bus.violation_code), 32'd3);

    // T6: freeze with enable low, then asynchronous reset mid-drain
    apply_reset("t6_rst");
    for (int i = 0; i < MAX_INSTS; i++) step(1'b1, 1'b1, ADDI_X1, "t6a");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, "t6b");
    step(1'b0, 1'b1, 32'hFFFF_FFF3, "t6c");
    check_val("t6_frz_const", 32'(bus.state), 32'd2);
    apply_reset("t6_arst");
    check_val("t6_arst_const", 32'(bus.state), 32'd0);
    step(1'b0, 1'b1, ADDI_X1, "t6d");

    // Randomized runs
    for (int r = 0; r < 14; r++) begin
      apply_reset("rnd_rst");
      for (int c = 0; c < 70; c++)
        step($urandom_range(0, 9) != 0, $urandom_range(0, 5) != 0, gen_instr(), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
